// File: rtl/cpu_load_sequencer_pkg.sv
// Shared types and constants for the CPU load/run/check sequencer.
package cpu_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_LOAD_I,
    S_RUN,
    S_READBACK,
    S_DONE
  } seq_state_t;

  localparam logic [6:0] STOP_OPC_DEFAULT = 7'b1111110;

  localparam logic [3:0] TID_BASIC = 4'd0;
  localparam logic [3:0] TID_MULT1 = 4'd1;
  localparam logic [3:0] TID_MULT2 = 4'd2;
  localparam logic [3:0] TID_MULT3 = 4'd3;
  localparam logic [3:0] TID_MULT4 = 4'd4;

endpackage

// File: rtl/cpu_load_sequencer_seq_addr_gen.sv
// Word-index counter producing a byte address (BASE + idx) << SHIFT.
module seq_addr_gen
  import cpu_tb_pkg::*;
#(
  parameter int unsigned AW    = 64,
  parameter int unsigned IW    = 16,
  parameter int unsigned SHIFT = 3,
  parameter int unsigned BASE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      idx <= '0;
    else if (inc)
      idx <= idx + IW'(1);
  end

  assign addr = (AW'(BASE) + AW'(idx)) << SHIFT;

endmodule

// File: rtl/cpu_load_sequencer.sv
// Preloads dmem/imem over the ext ports, runs the CPU to STOP or timeout,
// then reads back a dmem window against an expected-value ROM.
module cpu_load_sequencer
  import cpu_tb_pkg::*;
#(
  parameter int unsigned     IMEM_DW    = 32,
  parameter int unsigned     DMEM_DW    = 64,
  parameter int unsigned     AW         = 64,
  parameter int unsigned     IMEM_DEPTH = 128,
  parameter int unsigned     DMEM_DEPTH = 128,
  parameter int unsigned     CHK_BASE   = 35,
  parameter int unsigned     CHK_LEN    = 12,
  parameter logic [6:0]      STOP_OPC   = STOP_OPC_DEFAULT,
  parameter longint unsigned TIMEOUT    = 1048576
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [DMEM_DW-1:0]               ld_data,
  output logic [AW-1:0]                    addr_ext,
  output logic                             wen_ext,
  output logic [IMEM_DW-1:0]               wdata_ext,
  output logic                             ren_ext,
  output logic [AW-1:0]                    addr_ext_2,
  output logic                             wen_ext_2,
  output logic                             ren_ext_2,
  output logic [DMEM_DW-1:0]               wdata_ext_2,
  input  logic [DMEM_DW-1:0]               rdata_ext_2,
  input  logic [IMEM_DW-1:0]               instruction,
  output logic                             cpu_enable,
  output logic [$clog2(CHK_LEN+1)-1:0]     exp_idx,
  input  logic [DMEM_DW-1:0]               exp_data,
  output logic                             done,
  output logic                             pass,
  output logic                             timeout,
  output logic [3:0]                       test_id,
  output logic [31:0]                      cycles,
  output logic [$clog2(CHK_LEN+1)-1:0]     mism_cnt,
  output logic [$clog2(CHK_LEN+1)-1:0]     first_mism
);

  localparam int unsigned CW  = $clog2(CHK_LEN + 1);
  localparam int unsigned IW  = 16;
  localparam int unsigned DSH = $clog2(DMEM_DW / 8);
  localparam int unsigned ISH = $clog2(IMEM_DW / 8);

  seq_state_t    state;
  logic [31:0]   run_cnt;
  logic [CW-1:0] rb_cnt;
  logic [IW-1:0] d_idx, i_idx, r_idx;
  logic [AW-1:0] d_addr, i_addr, r_addr;
  logic          go, beat, stop_hit, at_limit, run_end, rd_issue, mism;
  logic          unused_instr;

  assign go       = start && (state == S_IDLE || state == S_DONE);
  assign beat     = ld_valid && ld_ready;
  assign stop_hit = instruction[6:0] == STOP_OPC;
  assign at_limit = run_cnt == 32'(TIMEOUT - 64'd1);
  assign run_end  = cpu_enable && (stop_hit || at_limit);
  // Read k is issued one cycle ahead so ren/addr are registered when visible.
  assign rd_issue = (state == S_RUN && run_end) ||
                    (state == S_READBACK && r_idx < IW'(CHK_LEN));
  assign mism     = (state == S_READBACK) && (rb_cnt != '0) && (rdata_ext_2 != exp_data);
  assign ren_ext  = 1'b0;
  assign unused_instr = ^instruction[27:7];

  seq_addr_gen #(.AW(AW), .IW(IW), .SHIFT(DSH), .BASE(0)) u_dgen (
    .clk(clk), .rst(rst), .clr(go), .inc(beat && state == S_LOAD_D),
    .idx(d_idx), .addr(d_addr)
  );

  seq_addr_gen #(.AW(AW), .IW(IW), .SHIFT(ISH), .BASE(0)) u_igen (
    .clk(clk), .rst(rst), .clr(go), .inc(beat && state == S_LOAD_I),
    .idx(i_idx), .addr(i_addr)
  );

  seq_addr_gen #(.AW(AW), .IW(IW), .SHIFT(DSH), .BASE(CHK_BASE)) u_rgen (
    .clk(clk), .rst(rst), .clr(!(state == S_RUN || state == S_READBACK)),
    .inc(rd_issue), .idx(r_idx), .addr(r_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ld_ready    <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cpu_enable  <= 1'b0;
      exp_idx     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      test_id     <= '0;
      cycles      <= '0;
      mism_cnt    <= '0;
      first_mism  <= '0;
      run_cnt     <= '0;
      rb_cnt      <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD_D;
            ld_ready   <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            mism_cnt   <= '0;
            first_mism <= '0;
          end
        end
        S_LOAD_D: begin
          if (beat) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= d_addr;
            wdata_ext_2 <= ld_data;
            if (d_idx == IW'(DMEM_DEPTH - 1))
              state <= S_LOAD_I;
          end
        end
        S_LOAD_I: begin
          if (beat) begin
            wen_ext   <= 1'b1;
            addr_ext  <= i_addr;
            wdata_ext <= ld_data[IMEM_DW-1:0];
            if (i_idx == IW'(IMEM_DEPTH - 1)) begin
              state    <= S_RUN;
              ld_ready <= 1'b0;
            end
          end
        end
        S_RUN: begin
          rb_cnt  <= '0;
          exp_idx <= '0;
          if (!cpu_enable) begin
            cpu_enable <= 1'b1;
            run_cnt    <= '0;
          end else if (stop_hit) begin
            cycles     <= run_cnt;
            test_id    <= instruction[31:28];
            cpu_enable <= 1'b0;
            state      <= S_READBACK;
          end else if (at_limit) begin
            cycles     <= run_cnt;
            timeout    <= 1'b1;
            cpu_enable <= 1'b0;
            state      <= S_READBACK;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        S_READBACK: begin
          exp_idx <= rb_cnt;
          rb_cnt  <= rb_cnt + CW'(1);
          if (mism) begin
            mism_cnt <= mism_cnt + CW'(1);
            if (mism_cnt == '0)
              first_mism <= exp_idx;
          end
          if (rb_cnt == CW'(CHK_LEN)) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= !timeout && (mism_cnt == '0) && !mism;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (rd_issue) begin
        ren_ext_2  <= 1'b1;
        addr_ext_2 <= r_addr;
      end
    end
  end

endmodule

// File: tb/tb_cpu_load_sequencer.sv
// Directed bench for cpu_load_sequencer with a dmem model and an expected ROM.
module tb_cpu_load_sequencer;

  localparam int unsigned     DDEP = 128;
  localparam int unsigned     IDEP = 128;
  localparam int unsigned     CB   = 35;
  localparam int unsigned     CL   = 12;
  localparam longint unsigned TO   = 600;
  localparam logic [31:0]     NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, start, ld_valid, ld_ready;
  logic [63:0] ld_data;
  logic [63:0] addr_ext, addr_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext, instruction, cycles;
  logic [63:0] wdata_ext_2, rdata_ext_2, exp_data;
  logic        cpu_enable, done, pass, timeout;
  logic [3:0]  exp_idx, mism_cnt, first_mism, test_id;

  int          n_checks = 0;
  int          n_err    = 0;
  int          rd_pulses = 0;
  int          rw_clash  = 0;
  logic [15:0] seed;
  logic        corrupt;
  logic [63:0] mem [0:127];

  cpu_load_sequencer #(
    .IMEM_DW(32), .DMEM_DW(64), .AW(64), .IMEM_DEPTH(IDEP), .DMEM_DEPTH(DDEP),
    .CHK_BASE(CB), .CHK_LEN(CL), .STOP_OPC(7'b1111110), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .ren_ext(ren_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .instruction(instruction), .cpu_enable(cpu_enable), .exp_idx(exp_idx),
    .exp_data(exp_data), .done(done), .pass(pass), .timeout(timeout),
    .test_id(test_id), .cycles(cycles), .mism_cnt(mism_cnt), .first_mism(first_mism)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dpat(input int i);
    return {16'hDA7A, seed, 16'(i), 16'(i * 3 + 7)};
  endfunction

  function automatic logic [31:0] ipat(input int i);
    return {seed ^ 16'h1A57, 16'(i)};
  endfunction

  assign exp_data = dpat(int'(CB) + int'(exp_idx));

  // dmem model: registered read, optional single-bit corruption of words CB+3 and CB+7
  always @(posedge clk) begin
    if (wen_ext_2) mem[addr_ext_2[9:3]] <= wdata_ext_2;
    if (ren_ext_2)
      rdata_ext_2 <= mem[addr_ext_2[9:3]] ^
        ((corrupt && (addr_ext_2[9:3] == 7'(CB + 3) || addr_ext_2[9:3] == 7'(CB + 7))) ? 64'h1 : 64'h0);
  end

  always @(negedge clk) begin
    if (ren_ext_2) rd_pulses++;
    if ((ren_ext_2 && (wen_ext_2 || wen_ext)) || ren_ext) rw_clash++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_seq();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("clr_on_start", {done, pass, timeout, mism_cnt, first_mism, ld_ready}, 64'h001);
  endtask

  task automatic load_beats(input bit toggle, input int limit);
    int sent = 0, nd = 0, ni = 0, cyc = 0, prev_idx = 0;
    logic acc_prev = 1'b0;
    while ((nd + ni) < limit && cyc < 4000) begin
      check_eq("wen_follows_beat", {wen_ext_2, wen_ext},
               acc_prev ? ((prev_idx < int'(DDEP)) ? 64'h2 : 64'h1) : 64'h0);
      if (wen_ext_2) begin
        check_eq("d_addr", addr_ext_2, 64'(nd * 8));
        check_eq("d_data", wdata_ext_2, dpat(nd));
        nd++;
      end
      if (wen_ext) begin
        check_eq("i_addr", addr_ext, 64'(ni * 4));
        check_eq("i_data", 64'(wdata_ext), 64'(ipat(ni)));
        ni++;
      end
      if ((nd + ni) >= limit) break;
      ld_valid = (sent < limit) && (!toggle || (cyc % 2 == 0));
      ld_data  = (sent < int'(DDEP)) ? dpat(sent) : {32'hFFFF_FFFF, ipat(sent - int'(DDEP))};
      acc_prev = ld_valid && ld_ready;
      prev_idx = sent;
      if (acc_prev) sent++;
      @(negedge clk);
      cyc++;
    end
    ld_valid = 1'b0;
    check_eq("load_count", 64'(nd + ni), 64'(limit));
  endtask

  task automatic post_load();
    check_eq("en_low_at_last_write", {cpu_enable, ld_ready}, 64'h0);
    @(negedge clk);
    check_eq("cpu_en_rise", 64'(cpu_enable), 64'h1);
  endtask

  task automatic run_stop(input int n, input logic [31:0] stop_instr);
    for (int k = 0; k < n; k++) begin
      instruction = NOP;
      @(negedge clk);
    end
    instruction = stop_instr;
    @(negedge clk);
    instruction = NOP;
    check_eq("stop_cpu_en_low", 64'(cpu_enable), 64'h0);
    check_eq("stop_cycles", 64'(cycles), 64'(n));
    check_eq("stop_test_id", 64'(test_id), 64'(stop_instr[31:28]));
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_reached", 64'(done), 64'h1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    instruction = NOP; corrupt = 1'b0; seed = 16'h0001;
    repeat (3) @(negedge clk);
    check_eq("reset_flags", {ld_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable,
                             done, pass, timeout, test_id, mism_cnt, first_mism, exp_idx}, 64'h0);
    check_eq("reset_cycles", 64'(cycles), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // A: clean load, STOP after 500 enabled cycles
    seed = 16'h0001; rd_pulses = 0;
    start_seq();
    load_beats(1'b0, 256);
    post_load();
    run_stop(500, 32'h4000_007E);
    wait_done(100, n);
    check_eq("A_rb_len", 64'(n), 64'd13);
    check_eq("A_result", {pass, timeout, mism_cnt, first_mism}, {54'd0, 1'b1, 1'b0, 4'd0, 4'd0});
    check_eq("A_reads", 64'(rd_pulses), 64'(CL));
    repeat (5) @(negedge clk);
    check_eq("A_hold", {done, pass, cycles}, {30'd0, 1'b1, 1'b1, 32'd500});

    // B: toggling ld_valid, mismatches at check indices 3 and 7
    seed = 16'h0002; corrupt = 1'b1;
    start_seq();
    load_beats(1'b1, 256);
    post_load();
    run_stop(10, 32'h1000_007E);
    wait_done(100, n);
    check_eq("B_result", {pass, timeout, mism_cnt, first_mism}, {54'd0, 1'b0, 1'b0, 4'd2, 4'd3});

    // C: no STOP, timeout after TO enabled cycles
    seed = 16'h0003; corrupt = 1'b0;
    start_seq();
    load_beats(1'b0, 256);
    post_load();
    wait_done(700, n);
    check_eq("C_done_latency", 64'(n), 64'(TO + CL + 1));
    check_eq("C_result", {pass, timeout, mism_cnt, cpu_enable}, {57'd0, 1'b0, 1'b1, 4'd0, 1'b0});

    // D: STOP on the final allowed cycle beats the timeout
    seed = 16'h0004;
    start_seq();
    load_beats(1'b0, 256);
    post_load();
    run_stop(int'(TO) - 1, 32'h2000_007E);
    wait_done(100, n);
    check_eq("D_result", {pass, timeout, mism_cnt}, {58'd0, 1'b1, 1'b0, 4'd0});

    // E: reset during LOAD_I, then a full reload from index 0
    seed = 16'h0005;
    start_seq();
    load_beats(1'b0, int'(DDEP) + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("E_reset_flags", {ld_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable,
                               done, pass, timeout, test_id, mism_cnt, first_mism, exp_idx}, 64'h0);
    check_eq("E_reset_cycles", 64'(cycles), 64'h0);
    check_eq("E_reset_addrs", addr_ext | addr_ext_2, 64'h0);
    @(negedge clk);
    check_eq("E_idle", {ld_ready, done}, 64'h0);
    start_seq();
    load_beats(1'b0, 256);
    post_load();
    run_stop(3, 32'h0000_007E);
    wait_done(100, n);
    check_eq("E_result", {pass, timeout, mism_cnt}, {58'd0, 1'b1, 1'b0, 4'd0});

    check_eq("no_rw_clash", 64'(rw_clash), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
